// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ==== pipeline_stall_controller : stall/flush sequencer for the 5-stage MIPS pipeline ====
// ==== rev 1.0 : explicit hazard FSM with saturating stall-cycle counter              ====
module pipeline_stall_controller #(
   parameter int BR_TIMEOUT = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_use_hazard,
   input  logic             branch_in_id,
   input  logic             branch_resolved,
   input  logic             branch_taken,
   input  logic             ex_busy,
   output logic             pc_write_en,
   output logic             if_id_write_en,
   output logic             id_ex_write_en,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic             pc_sel_branch,
   output logic             br_timeout_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [1:0]       state
);

   localparam int BR_W = $clog2(BR_TIMEOUT + 1);
   localparam logic [BR_W-1:0] BR_LAST = BR_W'(BR_TIMEOUT - 1);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      BR_WAIT = 2'd1,
      FLUSH   = 2'd2,
      EX_WAIT = 2'd3
   } state_t;

   state_t          cur_state;
   state_t          nxt_state;
   logic [BR_W-1:0] br_cnt;
   logic [BR_W-1:0] br_cnt_nxt;
   logic            err_set;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state      <= RUN;
         br_cnt         <= '0;
         br_timeout_err <= 1'b0;
         stall_cycles   <= '0;
      end else begin
         cur_state <= nxt_state;
         br_cnt    <= br_cnt_nxt;
         if (err_set)
            br_timeout_err <= 1'b1;
         if (!pc_write_en && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

   always_comb begin
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      id_ex_write_en = 1'b1;
      id_ex_bubble   = 1'b0;
      if_id_flush    = 1'b0;
      pc_sel_branch  = 1'b0;
      nxt_state      = cur_state;
      br_cnt_nxt     = br_cnt;
      err_set        = 1'b0;

      // A busy multicycle unit freezes the whole front end and the branch timer.
      if (ex_busy) begin
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         id_ex_write_en = 1'b0;
         if (cur_state == RUN)
            nxt_state = EX_WAIT;
      end else begin
         case (cur_state)
            RUN, EX_WAIT: begin
               nxt_state = RUN;
               if (load_use_hazard) begin
                  pc_write_en    = 1'b0;
                  if_id_write_en = 1'b0;
                  id_ex_bubble   = 1'b1;
               end else if (branch_in_id) begin
                  pc_write_en    = 1'b0;
                  if_id_write_en = 1'b0;
                  id_ex_bubble   = 1'b1;
                  nxt_state      = BR_WAIT;
                  br_cnt_nxt     = '0;
               end
            end
            BR_WAIT: begin
               pc_write_en    = 1'b0;
               if_id_write_en = 1'b0;
               id_ex_bubble   = 1'b1;
               br_cnt_nxt     = br_cnt + BR_W'(1);
               if (branch_resolved && branch_taken) begin
                  pc_write_en   = 1'b1;
                  pc_sel_branch = 1'b1;
                  if_id_flush   = 1'b1;
                  nxt_state     = FLUSH;
               end else if (branch_resolved) begin
                  pc_write_en    = 1'b1;
                  if_id_write_en = 1'b1;
                  nxt_state      = RUN;
               end else if (br_cnt == BR_LAST) begin
                  // Timed out: release as if not taken so the pipeline cannot lock up.
                  pc_write_en    = 1'b1;
                  if_id_write_en = 1'b1;
                  err_set        = 1'b1;
                  nxt_state      = RUN;
               end
            end
            FLUSH: begin
               id_ex_bubble = 1'b1;
               nxt_state    = RUN;
            end
            default: nxt_state = RUN;
         endcase
      end
   end

   assign state = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// Directed self-checking bench for pipeline_stall_controller.
module tb_pipeline_stall_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_use_hazard = 1'b0;
   logic        branch_in_id = 1'b0;
   logic        branch_resolved = 1'b0;
   logic        branch_taken = 1'b0;
   logic        ex_busy = 1'b0;
   logic        pc_write_en, if_id_write_en, id_ex_write_en;
   logic        id_ex_bubble, if_id_flush, pc_sel_branch, br_timeout_err;
   logic [15:0] stall_cycles;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   pipeline_stall_controller #(.BR_TIMEOUT(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_use_hazard(load_use_hazard), .branch_in_id(branch_in_id),
      .branch_resolved(branch_resolved), .branch_taken(branch_taken),
      .ex_busy(ex_busy),
      .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
      .id_ex_write_en(id_ex_write_en), .id_ex_bubble(id_ex_bubble),
      .if_id_flush(if_id_flush), .pc_sel_branch(pc_sel_branch),
      .br_timeout_err(br_timeout_err), .stall_cycles(stall_cycles), .state(state)
   );

   always #5 clk = ~clk;

   // {pc_we, if_id_we, id_ex_we, bubble, flush, pc_sel}
   wire [5:0] outs = {pc_write_en, if_id_write_en, id_ex_write_en,
                      id_ex_bubble, if_id_flush, pc_sel_branch};

   localparam logic [5:0] O_NORM   = 6'b111000;
   localparam logic [5:0] O_STALL  = 6'b001100;
   localparam logic [5:0] O_FREEZE = 6'b000000;
   localparam logic [5:0] O_TAKEN  = 6'b101111;
   localparam logic [5:0] O_REL    = 6'b111100;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      load_use_hazard = 1'b0;
      branch_in_id    = 1'b0;
      branch_resolved = 1'b0;
      branch_taken    = 1'b0;
      ex_busy         = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      @(negedge clk);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== O_NORM || state !== 2'd0 || stall_cycles !== 16'd0 || br_timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: outs=%b state=%0d stall=%0d err=%b, expected outs=%b state=0 stall=0 err=0",
                  outs, state, stall_cycles, br_timeout_err, O_NORM);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (outs !== O_NORM || state !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle[%0d]: outs=%b state=%0d, expected outs=%b state=0", i, outs, state, O_NORM);
         end
      end
      checks++;
      if (stall_cycles !== 16'd0) begin
         errors++;
         $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cycles);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      load_use_hazard = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== O_STALL || state !== 2'd0) begin
         errors++;
         $display("FAIL load_use_stall: outs=%b state=%0d, expected outs=%b state=0", outs, state, O_STALL);
      end
      tick();
      load_use_hazard = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== O_NORM || state !== 2'd0) begin
         errors++;
         $display("FAIL load_use_release: outs=%b state=%0d, expected outs=%b state=0", outs, state, O_NORM);
      end
      checks++;
      if (stall_cycles !== 16'd1) begin
         errors++;
         $display("FAIL load_use_stall_cnt: got %0d expected 1", stall_cycles);
      end
   endtask

   task automatic test_branch_taken();
      do_reset();
      branch_in_id = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== O_STALL || state !== 2'd0) begin
         errors++;
         $display("FAIL taken_detect: outs=%b state=%0d, expected outs=%b state=0", outs, state, O_STALL);
      end
      tick();
      // beq still in ID must not re-trigger while waiting
      @(negedge clk);
      checks++;
      if (outs !== O_STALL || state !== 2'd1) begin
         errors++;
         $display("FAIL taken_wait: outs=%b state=%0d, expected outs=%b state=1", outs, state, O_STALL);
      end
      tick();
      branch_in_id    = 1'b0;
      branch_resolved = 1'b1;
      branch_taken    = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== O_TAKEN || state !== 2'd1) begin
         errors++;
         $display("FAIL taken_resolve: outs=%b state=%0d, expected outs=%b state=1", outs, state, O_TAKEN);
      end
      tick();
      branch_resolved = 1'b0;
      branch_taken    = 1'b0;
      load_use_hazard = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== O_REL || state !== 2'd2) begin
         errors++;
         $display("FAIL taken_flush: outs=%b state=%0d, expected outs=%b state=2", outs, state, O_REL);
      end
      tick();
      load_use_hazard = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== O_NORM || state !== 2'd0 || stall_cycles !== 16'd2) begin
         errors++;
         $display("FAIL taken_done: outs=%b state=%0d stall=%0d, expected outs=%b state=0 stall=2",
                  outs, state, stall_cycles, O_NORM);
      end
   endtask

   task automatic test_branch_not_taken();
      do_reset();
      branch_in_id = 1'b1;
      tick();
      branch_in_id    = 1'b0;
      branch_resolved = 1'b1;
      branch_taken    = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== O_REL || state !== 2'd1) begin
         errors++;
         $display("FAIL not_taken_release: outs=%b state=%0d, expected outs=%b state=1", outs, state, O_REL);
      end
      tick();
      branch_resolved = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== O_NORM || state !== 2'd0 || stall_cycles !== 16'd1) begin
         errors++;
         $display("FAIL not_taken_done: outs=%b state=%0d stall=%0d, expected outs=%b state=0 stall=1",
                  outs, state, stall_cycles, O_NORM);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      branch_in_id = 1'b1;
      tick();
      branch_in_id = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (outs !== O_STALL || state !== 2'd1 || br_timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_wait[%0d]: outs=%b state=%0d err=%b, expected outs=%b state=1 err=0",
                     i, outs, state, br_timeout_err, O_STALL);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (outs !== O_REL || state !== 2'd1 || br_timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_release: outs=%b state=%0d err=%b, expected outs=%b state=1 err=0",
                  outs, state, br_timeout_err, O_REL);
      end
      tick();
      @(negedge clk);
      checks++;
      if (outs !== O_NORM || state !== 2'd0 || br_timeout_err !== 1'b1 || stall_cycles !== 16'd4) begin
         errors++;
         $display("FAIL timeout_flag: outs=%b state=%0d err=%b stall=%0d, expected outs=%b state=0 err=1 stall=4",
                  outs, state, br_timeout_err, stall_cycles, O_NORM);
      end
      repeat (3) tick();
      checks++;
      if (br_timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: got %b expected 1", br_timeout_err);
      end
      do_reset();
      @(negedge clk);
      checks++;
      if (br_timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear: got %b expected 0", br_timeout_err);
      end
   endtask

   task automatic test_ex_busy();
      do_reset();
      ex_busy         = 1'b1;
      load_use_hazard = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (outs !== O_FREEZE || state !== ((i == 0) ? 2'd0 : 2'd3)) begin
            errors++;
            $display("FAIL ex_busy_freeze[%0d]: outs=%b state=%0d, expected outs=%b state=%0d",
                     i, outs, state, O_FREEZE, (i == 0) ? 0 : 3);
         end
         tick();
      end
      ex_busy = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== O_STALL || state !== 2'd3) begin
         errors++;
         $display("FAIL ex_busy_release: outs=%b state=%0d, expected outs=%b state=3", outs, state, O_STALL);
      end
      tick();
      load_use_hazard = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== O_NORM || state !== 2'd0 || stall_cycles !== 16'd4) begin
         errors++;
         $display("FAIL ex_busy_done: outs=%b state=%0d stall=%0d, expected outs=%b state=0 stall=4",
                  outs, state, stall_cycles, O_NORM);
      end
   endtask

   task automatic test_busy_in_br_wait();
      do_reset();
      branch_in_id = 1'b1;
      tick();
      branch_in_id = 1'b0;
      tick();
      ex_busy = 1'b1;
      // Timer must freeze: 3 busy cycles would otherwise exhaust the timeout.
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (outs !== O_FREEZE || state !== 2'd1) begin
            errors++;
            $display("FAIL brwait_busy: outs=%b state=%0d, expected outs=%b state=1", outs, state, O_FREEZE);
         end
         tick();
      end
      ex_busy = 1'b0;
      tick();
      @(negedge clk);
      checks++;
      if (outs !== O_STALL || state !== 2'd1 || br_timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL brwait_busy_resume: outs=%b state=%0d err=%b, expected outs=%b state=1 err=0",
                  outs, state, br_timeout_err, O_STALL);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      branch_in_id = 1'b1;
      tick();
      branch_in_id = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (outs !== O_NORM || state !== 2'd0 || stall_cycles !== 16'd0) begin
         errors++;
         $display("FAIL reset_mid_stall: outs=%b state=%0d stall=%0d, expected outs=%b state=0 stall=0",
                  outs, state, stall_cycles, O_NORM);
      end
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_taken();
      test_branch_not_taken();
      test_timeout();
      test_ex_busy();
      test_busy_in_br_wait();
      test_reset_mid_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Takes hazard indications (load-use, beq in ID, multicycle EX unit busy) and branch resolution from EX.
- Drives the PC, IF/ID and ID/EX write enables, ID/EX bubble insertion, IF/ID flush and branch PC select.
- Replaces the ad-hoc hold logic with one explicit FSM and keeps a saturating stall-cycle counter for performance debug.

Parameters:
BR_TIMEOUT, 4, max cycles held in BR_WAIT without branch_resolved before forced release and error flag
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
load_use_hazard  input  1  ID/EX load writes rt read by the IF/ID instruction
branch_in_id  input  1  IF/ID opcode is beq
branch_resolved  input  1  beq in EX has computed its outcome this cycle
branch_taken  input  1  valid with branch_resolved; 1 = taken
ex_busy  input  1  multicycle EX unit (mult/div) not finished
pc_write_en  output  1  PC register load enable
if_id_write_en  output  1  IF/ID register load enable
id_ex_write_en  output  1  ID/EX register load enable
id_ex_bubble  output  1  zero ID/EX control fields (control mux select)
if_id_flush  output  1  clear IF/ID to nop on next edge
pc_sel_branch  output  1  PC mux selects branch target this cycle
br_timeout_err  output  1  sticky: BR_TIMEOUT expired
stall_cycles  output  CNT_W  saturating count of cycles with pc_write_en = 0
state  output  2  FSM state, debug

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = RUN, br counter = 0, stall_cycles = 0, br_timeout_err = 0.
  - Combinational outputs follow the RUN decode with all hazard inputs low: pc_write_en = if_id_write_en = id_ex_write_en = 1, all others 0.
- Outputs are a Mealy decode of (state, inputs) in the same cycle; state and counters update on the rising clk edge.
- States (encoding): RUN = 0, BR_WAIT = 1, FLUSH = 2, EX_WAIT = 3.
- Decode priority within any state: ex_busy > state-specific behaviour.
  - ex_busy = 1 in any state: pc_write_en = if_id_write_en = id_ex_write_en = 0, bubble = 0, flush = 0.
  - If ex_busy is asserted in RUN, next state = EX_WAIT.
  - In BR_WAIT or FLUSH, state holds and the br counter freezes.
- RUN:
  - load_use_hazard = 1: pc_write_en = 0, if_id_write_en = 0, id_ex_bubble = 1. State stays RUN, giving a 1-cycle stall.
  - Otherwise, branch_in_id = 1: same stall outputs, next = BR_WAIT, br counter cleared.
  - Load-use outranks branch_in_id. The beq is re-evaluated next cycle with IF/ID held.
  - Neither asserted: all write enables = 1, no bubble.
- BR_WAIT:
  - Per cycle: pc_write_en = 0, if_id_write_en = 0, id_ex_bubble = 1, br counter increments.
  - branch_resolved and taken: pc_write_en = 1, pc_sel_branch = 1, if_id_flush = 1, next = FLUSH.
  - branch_resolved and not taken: pc_write_en = 1, if_id_write_en = 1, id_ex_bubble = 1, next = RUN. This releases the stall so the fall-through instruction is fetched.
  - Not resolved and counter = BR_TIMEOUT − 1: br_timeout_err sets, next = RUN, same outputs as the not-taken release.
  - branch_in_id is ignored while in BR_WAIT, so the same beq cannot re-trigger.
- FLUSH:
  - One cycle: id_ex_bubble = 1, write enables = 1.
  - Next = RUN. Hazard inputs are ignored in this cycle.
- EX_WAIT:
  - Freeze outputs as above while ex_busy = 1.
  - First cycle ex_busy = 0: RUN decode applies to the current inputs, next = RUN.
- stall_cycles:
  - Increments on each clock edge where pc_write_en = 0.
  - Saturates at all-ones with no wrap.
- br_timeout_err clears only on reset.
- Reset asserted mid-stall returns immediately to RUN with counters cleared. No partial flush is issued.

Test Plan:
- Reset, all inputs 0 for 5 cycles -> pc/if_id/id_ex write enables = 1, state = 0, stall_cycles = 0.
- load_use_hazard = 1 for 1 cycle in RUN -> that cycle pc_write_en = 0, if_id_write_en = 0, id_ex_bubble = 1; next cycle back to normal; stall_cycles = 1.
- branch_in_id = 1, branch_resolved = 1 with taken = 1 two cycles later -> 2 stall cycles in BR_WAIT, then pc_sel_branch = 1 and if_id_flush = 1, then 1 FLUSH cycle with bubble, then RUN; stall_cycles = 2.
- branch_in_id then branch_resolved with taken = 0 -> release with pc_write_en = 1, if_id_flush = 0, pc_sel_branch = 0, state returns to 0.
- branch_in_id with branch_resolved never asserted -> after exactly 4 BR_WAIT cycles br_timeout_err = 1, state = RUN, error remains 1 until rst_n pulse.
- Simultaneous events: ex_busy = 1 for 3 cycles while load_use_hazard = 1 -> all write enables 0, no bubble; on release the load-use stall applies for 1 cycle; stall_cycles = 4.
